// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and error-cause codes for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_FUNCT3   = 2'b11;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Low address bits that may be non-zero for the access size (B: both, H: bit 1, W: none).
    function automatic logic [1:0] align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'b11;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);
    localparam int BE_W = XLEN / 8;

    logic [XLEN-1:0] shifted;

    always_comb begin
        be    = '1;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_W'(1) << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = BE_W'(3) << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend by size and signedness.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit with request/grant memory port and bus-error timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   regdata2,
    output logic              resp_valid,
    output logic [XLEN-1:0]   reg_write_value,
    output logic              err,
    output logic [1:0]        err_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output lsu_state_e        dbg_state
);
    // Handshake: an op is taken on a clock edge where op_valid && op_ready; mem_req is held
    // with stable address/be/wdata/we until an edge with mem_gnt; mem_rvalid counts only in REQ/WAIT.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e        state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        lat_lo;
    logic [2:0]        lat_f3;

    logic              mem_op, op_store, f3_ok, trap, tmo_hit;
    logic [1:0]        eff_lo, al_lo;
    logic [2:0]        al_f3;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wdata, al_load;

    assign mem_op   = is_load | is_store;
    assign op_store = is_store & ~is_load;
    assign f3_ok    = f3_legal(op_store, funct3);
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign eff_lo = alu_result[1:0];
    assign trap   = |(alu_result[1:0] & ~align_mask(funct3));
`else
    assign eff_lo = alu_result[1:0] & align_mask(funct3);
    assign trap   = 1'b0;
`endif

    // Steering follows the EX inputs while idle and the latched operands afterwards.
    assign al_lo = (state == ST_IDLE) ? eff_lo : lat_lo;
    assign al_f3 = (state == ST_IDLE) ? funct3 : lat_f3;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (al_lo),
        .funct3     (al_f3),
        .store_data (regdata2),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            tmo_cnt         <= '0;
            lat_lo          <= '0;
            lat_f3          <= '0;
            op_ready        <= 1'b1;
            resp_valid      <= 1'b0;
            reg_write_value <= '0;
            err             <= 1'b0;
            err_cause       <= CAUSE_NONE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= '0;
            mem_wdata       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (op_valid) begin
                    op_ready <= 1'b0;
                    if (!mem_op) begin
                        state           <= ST_RESP;
                        resp_valid      <= 1'b1;
                        reg_write_value <= alu_result;
                        err             <= 1'b0;
                        err_cause       <= CAUSE_NONE;
                    end else if (!f3_ok || trap) begin
                        state           <= ST_RESP;
                        resp_valid      <= 1'b1;
                        reg_write_value <= '0;
                        err             <= 1'b1;
                        err_cause       <= !f3_ok ? CAUSE_FUNCT3 : CAUSE_MISALIGN;
                    end else begin
                        state     <= ST_REQ;
                        tmo_cnt   <= '0;
                        lat_lo    <= eff_lo;
                        lat_f3    <= funct3;
                        mem_req   <= 1'b1;
                        mem_we    <= op_store;
                        mem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                        mem_be    <= al_be;
                        mem_wdata <= op_store ? al_wdata : '0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (mem_rvalid && (state == ST_WAIT || mem_gnt)) begin
                        state           <= ST_RESP;
                        mem_req         <= 1'b0;
                        resp_valid      <= 1'b1;
                        reg_write_value <= mem_we ? '0 : al_load;
                        err             <= 1'b0;
                        err_cause       <= CAUSE_NONE;
                    end else if (tmo_hit) begin
                        state           <= ST_RESP;
                        mem_req         <= 1'b0;
                        resp_valid      <= 1'b1;
                        reg_write_value <= '0;
                        err             <= 1'b1;
                        err_cause       <= CAUSE_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == ST_REQ && mem_gnt) begin
                            state   <= ST_WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    op_ready   <= 1'b1;
                    resp_valid <= 1'b0;
                    err        <= 1'b0;
                    err_cause  <= CAUSE_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized ops against a byte-level model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [XLEN-1:0]   alu_result = '0;
    logic [XLEN-1:0]   regdata2 = '0;
    logic              resp_valid;
    logic [XLEN-1:0]   reg_write_value;
    logic              err;
    logic [1:0]        err_cause;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;
    lsu_state_e        dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mem;
        logic [31:0] value;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    // Observations from the most recent run_op
    logic [31:0] o_value, o_addr, o_wdata;
    logic        o_err, o_we, o_req_seen, o_stable, o_done;
    logic [1:0]  o_cause;
    logic [3:0]  o_be;
    int          o_resps, o_lat, o_req_cycles;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .alu_result(alu_result), .regdata2(regdata2), .resp_valid(resp_valid),
        .reg_write_value(reg_write_value), .err(err), .err_cause(err_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Reference: byte-lane arithmetic straight from the load/store rules.
    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] rs2,
                                   input logic [31:0] rdata);
        exp_t   e;
        int     size, off;
        bit     legal, store;
        longint v;
        e.mem = 0; e.value = 0; e.err = 0; e.cause = 0; e.be = 0; e.wdata = 0; e.we = 0;
        e.maddr = addr - (addr % 4);
        store = st && !ld;
        if (!(ld || st)) begin
            e.value = addr;
            return e;
        end
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) begin
            e.err = 1; e.cause = 2'b11;
            return e;
        end
        off = int'(addr % 4);
        if (off % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            e.err = 1; e.cause = 2'b01;
            return e;
`else
            off = off - off % size;
`endif
        end
        e.mem = 1;
        e.we  = store;
        e.be  = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
        if (!store) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(rdata[8*(off+i) +: 8]) << (8*i);
            if (f3 < 3'd4 && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
            e.value = 32'(v);
        end
        return e;
    endfunction

    // Drives one op, plays memory (gnt after gnt_dly req cycles, rvalid rv_dly cycles after gnt)
    // and records what the DUT showed until it is ready again. o_lat counts edges after accept.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly, input bit never_gnt);
        bit granted, rv_sent;
        int gnt_cyc;
        granted = 0; rv_sent = 0; gnt_cyc = 0;
        o_req_seen = 0; o_req_cycles = 0; o_resps = 0; o_lat = -1; o_stable = 1; o_done = 0;
        o_value = '0; o_err = 0; o_cause = '0; o_addr = '0; o_be = '0; o_wdata = '0; o_we = 0;
        @(negedge clk);
        op_valid = 1; is_load = ld; is_store = st; funct3 = f3; alu_result = addr; regdata2 = rs2;
        @(negedge clk);
        op_valid = 0; is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
        alu_result = $urandom; regdata2 = $urandom;
        for (int cyc = 0; cyc < 400 && !o_done; cyc++) begin
            if (resp_valid) begin
                o_resps++;
                o_value = reg_write_value; o_err = err; o_cause = err_cause;
                if (o_lat < 0) o_lat = cyc;
            end
            if (mem_req) begin
                if (!o_req_seen) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
                    o_stable = 0;
                end
                o_req_seen = 1;
                o_req_cycles++;
            end
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (mem_req && !never_gnt && !granted && o_req_cycles > gnt_dly) begin
                mem_gnt = 1; granted = 1; gnt_cyc = cyc;
            end
            if (granted && !rv_sent && cyc >= gnt_cyc + rv_dly) begin
                mem_rvalid = 1; mem_rdata = rdata; rv_sent = 1;
            end
            if (o_resps > 0 && op_ready) o_done = 1;
            else @(negedge clk);
        end
        mem_gnt = 0; mem_rvalid = 0;
        checks++;
        if (!o_done) begin
            errors++;
            $display("FAIL op_done: no completion within 400 cycles (resps=%0d), required completion", o_resps);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({op_ready, resp_valid, mem_req, err, mem_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/resp/req/err/we=%b required 10000",
                     {op_ready, resp_valid, mem_req, err, mem_we});
        end
        checks++;
        if ({reg_write_value, mem_addr, mem_wdata, mem_be, err_cause} !== '0) begin
            errors++;
            $display("FAIL reset_data: value=%h addr=%h wdata=%h be=%b cause=%b required all zero",
                     reg_write_value, mem_addr, mem_wdata, mem_be, err_cause);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fast_path();
        run_op(0, 0, 3'($urandom), 32'h42, $urandom, $urandom, 0, 0, 0);
        checks++;
        if ({o_value, o_err, o_req_seen} !== {32'h42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fast_value: value=%h err=%b req=%b required 00000042 0 0", o_value, o_err, o_req_seen);
        end
        checks++;
        if (o_lat !== 0 || o_resps !== 1) begin
            errors++;
            $display("FAIL fast_latency: lat=%0d pulses=%0d required 0 1", o_lat, o_resps);
        end
    endtask

    // mem_req rises the cycle after the op; gnt one cycle later, rvalid the next, then resp_valid.
    task automatic test_lw_timing();
        run_op(1, 0, F3_W, 32'h100, $urandom, 32'hDEAD_BEEF, 1, 1, 0);
        checks++;
        if ({o_value, o_err} !== {32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL lw_value: value=%h err=%b required deadbeef 0", o_value, o_err);
        end
        checks++;
        if (o_lat !== 3 || o_resps !== 1) begin
            errors++;
            $display("FAIL lw_latency: lat=%0d pulses=%0d required 3 1", o_lat, o_resps);
        end
        checks++;
        if ({o_addr, o_be, o_we, o_stable} !== {32'h100, 4'b1111, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL lw_port: addr=%h be=%b we=%b stable=%b required 00000100 1111 0 1",
                     o_addr, o_be, o_we, o_stable);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s   [3] = '{F3_B, F3_BU, F3_HU};
        logic [31:0] addrs [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] exps  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
        for (int i = 0; i < 3; i++) begin
            run_op(1, 0, f3s[i], addrs[i], $urandom, 32'h80FF_FFFF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
            checks++;
            if ({o_value, o_err} !== {exps[i], 1'b0}) begin
                errors++;
                $display("FAIL load_extend[%0d]: value=%h err=%b required %h 0", i, o_value, o_err, exps[i]);
            end
        end
    endtask

    task automatic test_store_lanes();
        run_op(0, 1, F3_B, 32'h0201, 32'h1234_5678, $urandom, 0, 1, 0);
        checks++;
        if ({o_addr, o_be, o_wdata, o_we, o_value} !== {32'h200, 4'b0010, 32'h7878_7878, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL sb_port: addr=%h be=%b wdata=%h we=%b value=%h required 00000200 0010 78787878 1 0",
                     o_addr, o_be, o_wdata, o_we, o_value);
        end
        run_op(0, 1, F3_H, 32'h0202, 32'h1234_5678, $urandom, 2, 0, 0);
        checks++;
        if ({o_be, o_wdata, o_we, o_stable} !== {4'b1100, 32'h5678_5678, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sh_port: be=%b wdata=%h we=%b stable=%b required 1100 56785678 1 1",
                     o_be, o_wdata, o_we, o_stable);
        end
    endtask

    task automatic test_misalign();
        run_op(1, 0, F3_W, 32'h102, $urandom, 32'hCAFE_F00D, 0, 0, 0);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if ({o_err, o_cause, o_req_seen} !== {1'b1, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL misalign_trap: err=%b cause=%b req=%b required 1 01 0", o_err, o_cause, o_req_seen);
        end
`else
        if ({o_err, o_addr, o_be, o_value} !== {1'b0, 32'h100, 4'b1111, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL misalign_force: err=%b addr=%h be=%b value=%h required 0 00000100 1111 cafef00d",
                     o_err, o_addr, o_be, o_value);
        end
`endif
    endtask

    task automatic test_bad_funct3();
        run_op(0, 1, 3'b011, 32'h400, $urandom, $urandom, 0, 0, 0);
        checks++;
        if ({o_err, o_cause, o_req_seen, o_lat} !== {1'b1, 2'b11, 1'b0, 0}) begin
            errors++;
            $display("FAIL bad_f3_store: err=%b cause=%b req=%b lat=%0d required 1 11 0 0", o_err, o_cause, o_req_seen, o_lat);
        end
        run_op(1, 1, 3'b110, 32'h400, $urandom, $urandom, 0, 0, 0);
        checks++;
        if ({o_err, o_cause, o_req_seen} !== {1'b1, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL bad_f3_load: err=%b cause=%b req=%b required 1 11 0", o_err, o_cause, o_req_seen);
        end
    endtask

    task automatic test_timeout();
        bit late_resp;
        run_op(1, 0, F3_W, 32'h500, $urandom, $urandom, 0, 0, 1);
        checks++;
        if ({o_err, o_cause} !== {1'b1, 2'b10}) begin
            errors++;
            $display("FAIL timeout_err: err=%b cause=%b required 1 10", o_err, o_cause);
        end
        checks++;
        if (o_req_cycles !== TIMEOUT || o_lat !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: req_cycles=%0d lat=%0d required %0d %0d", o_req_cycles, o_lat, TIMEOUT, TIMEOUT);
        end
        late_resp = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1; mem_rdata = $urandom;
            @(negedge clk);
            if (resp_valid || mem_req) late_resp = 1;
        end
        mem_rvalid = 0;
        checks++;
        if (late_resp !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: response or request seen=%b required 0", late_resp);
        end
        run_op(1, 0, F3_H, 32'h502, $urandom, 32'h8001_0000, 0, 0, 0);
        checks++;
        if ({o_value, o_err} !== {32'hFFFF_8001, 1'b0}) begin
            errors++;
            $display("FAIL after_timeout: value=%h err=%b required ffff8001 0", o_value, o_err);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        int          r;
        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            ld = (r == 1) || (r >= 2 && r <= 5);
            st = (r == 1) || (r >= 6);
            f3 = (n % 4 == 0) ? 3'($urandom) : ((r >= 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr = $urandom; rs2 = $urandom; rdata = $urandom;
            e = model(ld, st, f3, addr, rs2, rdata);
            run_op(ld, st, f3, addr, rs2, rdata, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            checks++;
            if ({o_value, o_err, o_cause, o_req_seen} !== {e.value, e.err, e.cause, e.mem} || o_resps !== 1) begin
                errors++;
                $display("FAIL rand_resp[%0d]: value=%h err=%b cause=%b req=%b pulses=%0d required %h %b %b %b 1",
                         n, o_value, o_err, o_cause, o_req_seen, o_resps, e.value, e.err, e.cause, e.mem);
            end
            if (e.mem) begin
                checks++;
                if ({o_addr, o_be, o_we, o_stable} !== {e.maddr, e.be, e.we, 1'b1} ||
                    (e.we && o_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL rand_port[%0d]: addr=%h be=%b we=%b wdata=%h stable=%b required %h %b %b %h 1",
                             n, o_addr, o_be, o_we, o_wdata, o_stable, e.maddr, e.be, e.we, e.wdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        op_valid = 1; is_load = 1; is_store = 0; funct3 = F3_W; alu_result = 32'h300;
        @(negedge clk);
        op_valid = 0;
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        checks++;
        if (dbg_state !== ST_WAIT) begin
            errors++;
            $display("FAIL mid_wait: state=%0d required %0d", dbg_state, ST_WAIT);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({resp_valid, mem_req, op_ready} !== 3'b001 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL mid_reset: resp/req/ready=%b state=%0d required 001 %0d",
                     {resp_valid, mem_req, op_ready}, dbg_state, ST_IDLE);
        end
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        mem_rvalid = 1; mem_rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 0;
            if (resp_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_resp: resp_valid seen=%b required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_fast_path();
        test_lw_timing();
        test_load_extend();
        test_store_lanes();
        test_misalign();
        test_bad_funct3();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
